ppu_vram_port: RTL and testbench
================================

// Module: ppu_vram_port
// PURPOSE
//  PPU-side VRAM responder: answers address requests from the PPU background/sprite fetchers and
//  serves CPU $2006/$2007 accesses. Decodes the 14-bit PPU space into CHR (external), 2 KB internal
//  nametable RAM with H/V mirroring, and 32x6 palette RAM. Arbitrates between fetch and CPU use.
// PARAMETERS
//  NT_BYTES    2048  internal nametable RAM size; power of two, >= 2048
//  PAL_ENTRIES 32    palette RAM entries, 6 bits each
// PORTS
//  clk            in   1   system clock; single clock domain
//  reset          in   1   synchronous, active-high reset
//  fetch_addr     in   16  fetcher address; bits [15:14] ignored
//  fetch_data     out  8   read data for fetch_addr, combinational
//  rendering      in   1   1 = fetchers own memory; CPU memory access deferred
//  mirror_vert    in   1   1 = vertical mirroring (A10 select), 0 = horizontal (A11 select)
//  inc32          in   1   PPUCTRL bit 2: $2007 increment is 32, else 1
//  cpu_sel        in   3   register select, CPU A[2:0]
//  cpu_wr         in   1   one-cycle write strobe
//  cpu_rd         in   1   one-cycle read strobe
//  cpu_wdata      in   8   CPU write data
//  cpu_rdata      out  8   $2007 read data, valid the cycle after cpu_rd
//  chr_addr       out  13  CHR address to cartridge
//  chr_rdata      in   8   CHR read data, combinational from chr_addr
//  chr_wdata      out  8   CHR write data
//  chr_we         out  1   CHR write strobe, one cycle
// BEHAVIOUR
//  Reset: cpu_addr=0, w_toggle=0, rd_buf=0, state=IDLE, cpu_rdata=0, chr_we=0, chr_wdata=0.
//  Decode (a = addr[13:0]): $0000-$1FFF CHR; $2000-$3EFF nametable, fold to
//   {vert ? a[10] : a[11], a[9:0]}; $3F00-$3FFF palette, index a[4:0] with 5'h10/14/18/1C -> 5'h00/04/08/0C.
//   Palette reads return {2'b00, entry}.
//  Fetch path: fetch_data purely combinational from fetch_addr, zero cycles. Memory reads are
//   asynchronous, and CHR passes through. chr_addr = fetch_addr[12:0] when rendering=1, else cpu_addr[12:0].
//  $2002 read (sel 2, cpu_rd): w_toggle <= 0. Status data is not driven here.
//  $2006 write: w_toggle=0 -> cpu_addr[13:8] <= wdata[5:0], toggle 1. w_toggle=1 -> cpu_addr[7:0] <= wdata, toggle 0.
//  $2007 write: capture (cpu_addr, wdata), state <= WR_PEND, cpu_addr += inc32 ? 32 : 1.
//  $2007 read: cpu_rdata <= rd_buf (palette addr: cpu_rdata <= palette entry),
//   state <= RD_PEND with latched addr, cpu_addr += inc.
//   The buffer fill for a palette address reads nametable at (addr - $1000).
//  cpu_addr arithmetic is 14-bit and wraps $3FFF -> $0000.
//  FSM IDLE/WR_PEND/RD_PEND: in a pending state with rendering=0, perform the op this cycle,
//   then go to IDLE. WR_PEND writes NT/palette, or pulses chr_we for CHR. RD_PEND loads rd_buf.
//   Pending ops wait while rendering=1. Lost ops are not queued.
//  New $2007 access while pending: the pending op is committed first in the same cycle if rendering=0,
//   else the new op replaces it (last-write-wins); the address still increments.
//  cpu_wr and cpu_rd in the same cycle: write has priority, read ignored.
//  Reset mid-pending: the op is dropped, with no memory side effects.
// CONFIGURATION
//  CHR_RAM_EN defined: CHR-region writes drive chr_wdata/chr_we.
//  CHR_RAM_EN undefined: chr_we tied 0; CHR-region writes go to IDLE with no effect.
// STRUCTURE
//  ppu_pkg: vram_region_e {REG_CHR, REG_NT, REG_PAL}, port_state_e, PAL_BASE=14'h3F00,
//   NT_BASE=14'h2000, function nt_fold(addr, vert), function pal_fold(addr).
//  Sub-module ppu_palette_ram: 32x6, async read, sync write, applies pal_fold internally.
//  Nametable RAM stays inline as an inferred async-read array.
// TESTING
//  1. Write $2006 $21, $2006 $08, $2007 $5A, rendering=0 -> NT[$108]=$5A; cpu_addr=$2109.
//  2. mirror_vert=1, NT write at $2005=$77 -> fetch_addr $2805 returns $77, fetch_addr $2405 does not.
//  3. Palette write $3F10=$2C -> fetch $3F00 returns $2C; a $2007 read at $3F10 returns $2C immediately.
//  4. Buffered read: NT[$2000]=$11, [$2001]=$22; addr $2000, two $2007 reads -> stale buffer, then $11.
//  5. inc32=1, rendering=1, $2007 write $99 at $23E0 -> no memory change while rendering;
//     committed on the first rendering=0 cycle; cpu_addr=$2400.
//  6. cpu_addr=$3FFF, $2007 write -> cpu_addr wraps to $0000. With CHR_RAM_EN, a write at
//     $0010 gives chr_we pulse with chr_addr=$0010.

Source files
------------

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and address helpers for the PPU VRAM port.
// Regions, port FSM states, base addresses, nametable/palette folding.
package ppu_pkg;

  typedef enum logic [1:0] {
    REG_CHR,
    REG_NT,
    REG_PAL
  } vram_region_e;

  typedef enum logic [1:0] {
    IDLE,
    WR_PEND,
    RD_PEND
  } port_state_e;

  localparam logic [13:0] PAL_BASE = 14'h3F00;
  localparam logic [13:0] NT_BASE  = 14'h2000;

  function automatic vram_region_e region_of(
    input logic [13:0] a
  );
    if (a < NT_BASE)       return REG_CHR;
    else if (a < PAL_BASE) return REG_NT;
    else                   return REG_PAL;
  endfunction

  // Horizontal mirroring pairs banks on A11, vertical on A10.
  function automatic logic [10:0] nt_fold(
    input logic [13:0] a,
    input logic        vert
  );
    return {vert ? a[10] : a[11], a[9:0]};
  endfunction

  // Sprite backdrop slots $10/$14/$18/$1C alias the bg ones.
  function automatic logic [4:0] pal_fold(
    input logic [4:0] idx
  );
    logic [4:0] r;
    r = idx;
    if (idx[1:0] == 2'b00) r[4] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/ppu_palette_ram.sv
// ppu_palette_ram: 32x6 palette store, async reads, sync write.
// Ports: clk, we/waddr/wdata, two read ports (a: fetch, b: CPU).
module ppu_palette_ram
  import ppu_pkg::*;
#(
  parameter int ENTRIES = 32
) (
  input  logic       clk,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [5:0] wdata,
  input  logic [4:0] raddr_a,
  output logic [5:0] rdata_a,
  input  logic [4:0] raddr_b,
  output logic [5:0] rdata_b
);

  logic [5:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) mem[pal_fold(waddr)] <= wdata;
  end

  assign rdata_a = mem[pal_fold(raddr_a)];
  assign rdata_b = mem[pal_fold(raddr_b)];

endmodule

// File: rtl/ppu_vram_port.sv
// ppu_vram_port: PPU memory responder for fetchers and CPU $2006/$2007.
// Ports: clk, reset (sync, high); fetch_addr/fetch_data (comb);
//  rendering, mirror_vert, inc32; cpu_sel/wr/rd/wdata/rdata;
//  chr_addr/rdata/wdata/we to cartridge.
// Build option: CHR_RAM_EN enables CHR-region writes via chr_we.
module ppu_vram_port
  import ppu_pkg::*;
#(
  parameter int NT_BYTES    = 2048,
  parameter int PAL_ENTRIES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] fetch_addr,
  output logic [7:0]  fetch_data,
  input  logic        rendering,
  input  logic        mirror_vert,
  input  logic        inc32,
  input  logic [2:0]  cpu_sel,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [12:0] chr_addr,
  input  logic [7:0]  chr_rdata,
  output logic [7:0]  chr_wdata,
  output logic        chr_we
);

  localparam int NT_AW = $clog2(NT_BYTES);

  function automatic logic [NT_AW-1:0] nt_idx(
    input logic [13:0] a,
    input logic        vert
  );
    return NT_AW'(nt_fold(a, vert));
  endfunction

  logic [13:0]  cpu_addr;
  logic [13:0]  pend_addr;
  logic [7:0]   pend_data;
  logic [7:0]   rd_buf;
  logic         w_toggle;
  port_state_e  state;

  logic [7:0]   nt_mem [NT_BYTES];

  logic [13:0]  fa;
  logic [5:0]   pal_f;
  logic [5:0]   pal_c;
  vram_region_e pend_reg;
  logic [13:0]  fill_addr;
  logic [7:0]   fill_data;
  logic [7:0]   rd_buf_nxt;
  logic [13:0]  inc;
  logic         wr6, wr7, rd2, rd7;
  logic         commit, do_wr;
  logic         nt_we, pal_we;
  logic         unused_bits;

  assign fa          = fetch_addr[13:0];
  assign unused_bits = ^{fetch_addr[15:14], pend_data[7:6]};

  // Write wins over a simultaneous read.
  assign wr6 = cpu_wr && (cpu_sel == 3'd6);
  assign wr7 = cpu_wr && (cpu_sel == 3'd7);
  assign rd2 = cpu_rd && !cpu_wr && (cpu_sel == 3'd2);
  assign rd7 = cpu_rd && !cpu_wr && (cpu_sel == 3'd7);
  assign inc = inc32 ? 14'd32 : 14'd1;

  ppu_palette_ram #(
    .ENTRIES (PAL_ENTRIES)
  ) u_pal (
    .clk     (clk),
    .we      (pal_we),
    .waddr   (pend_addr[4:0]),
    .wdata   (pend_data[5:0]),
    .raddr_a (fa[4:0]),
    .rdata_a (pal_f),
    .raddr_b (cpu_addr[4:0]),
    .rdata_b (pal_c)
  );

  always_comb begin
    fetch_data = 8'h00;
    unique case (region_of(fa))
      REG_CHR: fetch_data = chr_rdata;
      REG_NT:  fetch_data = nt_mem[nt_idx(fa, mirror_vert)];
      default: fetch_data = {2'b00, pal_f};
    endcase
  end

  assign pend_reg = region_of(pend_addr);

  // A CHR read fill must not sample the bus while a CHR write
  // still owns chr_addr, so it slips one cycle.
  assign commit = (state != IDLE) && !rendering &&
                  !(chr_we && state == RD_PEND);
  assign do_wr  = commit && (state == WR_PEND) && !reset;
  assign nt_we  = do_wr && (pend_reg == REG_NT);
  assign pal_we = do_wr && (pend_reg == REG_PAL);

  // Palette addresses fill the buffer from the NT underneath.
  assign fill_addr = (pend_reg == REG_PAL) ?
                     pend_addr - 14'h1000 : pend_addr;

  always_comb begin
    fill_data = nt_mem[nt_idx(fill_addr, mirror_vert)];
    if (pend_reg == REG_CHR) fill_data = chr_rdata;
  end

  assign rd_buf_nxt = (commit && state == RD_PEND) ?
                      fill_data : rd_buf;

  always_ff @(posedge clk) begin
    if (nt_we) nt_mem[nt_idx(pend_addr, mirror_vert)] <= pend_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_addr  <= 14'h0000;
      pend_addr <= 14'h0000;
      pend_data <= 8'h00;
      w_toggle  <= 1'b0;
      rd_buf    <= 8'h00;
      cpu_rdata <= 8'h00;
      state     <= IDLE;
    end else begin
      rd_buf <= rd_buf_nxt;
      if (commit) state <= IDLE;
      if (wr6) begin
        if (!w_toggle) cpu_addr[13:8] <= cpu_wdata[5:0];
        else           cpu_addr[7:0]  <= cpu_wdata;
        w_toggle <= ~w_toggle;
      end
      if (rd2) w_toggle <= 1'b0;
      // An uncommitted pending op is simply overwritten here.
      if (wr7) begin
        state     <= WR_PEND;
        pend_addr <= cpu_addr;
        pend_data <= cpu_wdata;
        cpu_addr  <= cpu_addr + inc;
      end else if (rd7) begin
        if (region_of(cpu_addr) == REG_PAL)
          cpu_rdata <= {2'b00, pal_c};
        else
          cpu_rdata <= rd_buf_nxt;
        state     <= RD_PEND;
        pend_addr <= cpu_addr;
        cpu_addr  <= cpu_addr + inc;
      end
    end
  end

`ifdef CHR_RAM_EN
  logic [12:0] chr_waddr;
  logic        chr_do;

  assign chr_do = do_wr && (pend_reg == REG_CHR);

  always_ff @(posedge clk) begin
    if (reset) begin
      chr_we    <= 1'b0;
      chr_wdata <= 8'h00;
      chr_waddr <= 13'h0000;
    end else begin
      chr_we <= chr_do;
      if (chr_do) begin
        chr_wdata <= pend_data;
        chr_waddr <= pend_addr[12:0];
      end
    end
  end

  // The write pulse holds the bus so the cart sees its address.
  always_comb begin
    chr_addr = cpu_addr[12:0];
    if (chr_we)                 chr_addr = chr_waddr;
    else if (rendering)         chr_addr = fetch_addr[12:0];
    else if (state == RD_PEND)  chr_addr = pend_addr[12:0];
  end
`else
  assign chr_we    = 1'b0;
  assign chr_wdata = 8'h00;

  always_comb begin
    chr_addr = cpu_addr[12:0];
    if (rendering)              chr_addr = fetch_addr[12:0];
    else if (state == RD_PEND)  chr_addr = pend_addr[12:0];
  end
`endif

endmodule

// File: tb/tb_ppu_vram_port.sv
// tb_ppu_vram_port: directed bench for ppu_vram_port.
// Linear register-level sequence with hand-computed expectations.
module tb_ppu_vram_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] fetch_addr;
  logic [7:0]  fetch_data;
  logic        rendering, mirror_vert, inc32;
  logic [2:0]  cpu_sel;
  logic        cpu_wr, cpu_rd;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic [12:0] chr_addr;
  logic [7:0]  chr_rdata;
  logic [7:0]  chr_wdata;
  logic        chr_we;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Cartridge model: CHR byte is a fixed function of the address.
  assign chr_rdata = chr_addr[7:0] ^ 8'h5C;

  ppu_vram_port dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_addr  (fetch_addr),
    .fetch_data  (fetch_data),
    .rendering   (rendering),
    .mirror_vert (mirror_vert),
    .inc32       (inc32),
    .cpu_sel     (cpu_sel),
    .cpu_wr      (cpu_wr),
    .cpu_rd      (cpu_rd),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .chr_addr    (chr_addr),
    .chr_rdata   (chr_rdata),
    .chr_wdata   (chr_wdata),
    .chr_we      (chr_we)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [2:0] s, input logic [7:0] d);
    cpu_sel   = s;
    cpu_wdata = d;
    cpu_wr    = 1'b1;
    cyc();
    cpu_wr    = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] s);
    cpu_sel = s;
    cpu_rd  = 1'b1;
    cyc();
    cpu_rd  = 1'b0;
  endtask

  task automatic set_addr(input logic [15:0] a);
    reg_wr(3'd6, a[15:8]);
    reg_wr(3'd6, a[7:0]);
  endtask

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic peek(input logic [15:0] a,
                      input string tag,
                      input logic [7:0] exp);
    fetch_addr = a;
    #1;
    check(tag, {8'h00, fetch_data}, {8'h00, exp});
  endtask

  initial begin
    reset = 1'b1;
    fetch_addr = 16'h0000;
    rendering = 1'b0;
    mirror_vert = 1'b0;
    inc32 = 1'b0;
    cpu_sel = 3'd0;
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
    cpu_wdata = 8'h00;
    repeat (2) cyc();
    check("rst_rdata", {8'h00, cpu_rdata}, 16'h0000);
    check("rst_chr_we", {15'h0, chr_we}, 16'h0000);
    check("rst_chr_wdata", {8'h00, chr_wdata}, 16'h0000);
    check("rst_addr", {2'b00, dut.cpu_addr}, 16'h0000);
    reset = 1'b0;
    cyc();

    // 1: $2108 <- $5A, horizontal mirroring
    set_addr(16'h2108);
    reg_wr(3'd7, 8'h5A);
    cyc();
    check("t1_addr", {2'b00, dut.cpu_addr}, 16'h2109);
    check("t1_chr_addr_idle", {3'b000, chr_addr}, 16'h0109);
    peek(16'h2108, "t1_nt", 8'h5A);
    peek(16'h2508, "t1_hmirror", 8'h5A);
    peek(16'hE108, "t1_hi_bits", 8'h5A);

    // 2: vertical mirroring, $2005 <- $77, $2405 preset $00
    mirror_vert = 1'b1;
    set_addr(16'h2405);
    reg_wr(3'd7, 8'h00);
    set_addr(16'h2005);
    reg_wr(3'd7, 8'h77);
    cyc();
    peek(16'h2805, "t2_vmirror", 8'h77);
    peek(16'h2405, "t2_other_bank", 8'h00);

    // 3: palette aliasing and unbuffered palette reads
    set_addr(16'h2F10);
    reg_wr(3'd7, 8'hA5);
    set_addr(16'h3F10);
    reg_wr(3'd7, 8'h2C);
    cyc();
    peek(16'h3F00, "t3_pal_alias", 8'h2C);
    peek(16'h3F10, "t3_pal_direct", 8'h2C);
    set_addr(16'h3F01);
    reg_wr(3'd7, 8'hFF);
    cyc();
    peek(16'h3F01, "t3_pal_6bit", 8'h3F);
    set_addr(16'h3F10);
    reg_rd(3'd7);
    check("t3_pal_read", {8'h00, cpu_rdata}, 16'h002C);
    cyc();

    // 4: back-to-back writes, buffered reads
    mirror_vert = 1'b0;
    set_addr(16'h2000);
    reg_wr(3'd7, 8'h11);
    reg_wr(3'd7, 8'h22);
    cyc();
    set_addr(16'h2000);
    reg_rd(3'd7);
    check("t4_stale", {8'h00, cpu_rdata}, 16'h00A5);
    reg_rd(3'd7);
    check("t4_buf1", {8'h00, cpu_rdata}, 16'h0011);
    reg_rd(3'd7);
    check("t4_buf2", {8'h00, cpu_rdata}, 16'h0022);
    set_addr(16'h2003);
    cpu_sel = 3'd7;
    cpu_wdata = 8'h33;
    cpu_wr = 1'b1;
    cpu_rd = 1'b1;
    cyc();
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
    check("t4_rdwr_rdata", {8'h00, cpu_rdata}, 16'h0022);
    check("t4_rdwr_addr", {2'b00, dut.cpu_addr}, 16'h2004);
    cyc();
    peek(16'h2003, "t4_rdwr_mem", 8'h33);

    // 5: deferred write during rendering, inc32
    set_addr(16'h23E0);
    reg_wr(3'd7, 8'h00);
    cyc();
    set_addr(16'h23E0);
    inc32 = 1'b1;
    rendering = 1'b1;
    reg_wr(3'd7, 8'h99);
    check("t5_addr", {2'b00, dut.cpu_addr}, 16'h2400);
    repeat (3) cyc();
    peek(16'h23E0, "t5_deferred", 8'h00);
    check("t5_chr_addr_fetch", {3'b000, chr_addr}, 16'h03E0);
    peek(16'h0123, "t5_chr_pass", 8'h7F);
    rendering = 1'b0;
    cyc();
    peek(16'h23E0, "t5_committed", 8'h99);
    inc32 = 1'b0;

    // $2002 read clears the write toggle
    reg_wr(3'd6, 8'h21);
    reg_rd(3'd2);
    set_addr(16'h3F00);
    check("t5_toggle_clr", {2'b00, dut.cpu_addr}, 16'h3F00);

    // 6: address wrap and CHR writes
    set_addr(16'h3FFF);
    reg_wr(3'd7, 8'h12);
    check("t6_wrap", {2'b00, dut.cpu_addr}, 16'h0000);
    cyc();
    peek(16'h3F1F, "t6_pal_1f", 8'h12);
    set_addr(16'h0010);
    reg_wr(3'd7, 8'hAB);
    cyc();
`ifdef CHR_RAM_EN
    check("t6_chr_we", {15'h0, chr_we}, 16'h0001);
    check("t6_chr_addr", {3'b000, chr_addr}, 16'h0010);
    check("t6_chr_wdata", {8'h00, chr_wdata}, 16'h00AB);
    cyc();
    check("t6_chr_we_end", {15'h0, chr_we}, 16'h0000);
`else
    check("t6_chr_we_off", {15'h0, chr_we}, 16'h0000);
    check("t6_chr_wdata_off", {8'h00, chr_wdata}, 16'h0000);
`endif
    check("t6_chr_addr_post", {2'b00, dut.cpu_addr}, 16'h0011);

    // reset while a write is pending drops it
    set_addr(16'h2001);
    rendering = 1'b1;
    reg_wr(3'd7, 8'hEE);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rendering = 1'b0;
    repeat (2) cyc();
    peek(16'h2001, "rst_drop_mem", 8'h22);
    check("rst_drop_addr", {2'b00, dut.cpu_addr}, 16'h0000);
    check("rst_drop_rdata", {8'h00, cpu_rdata}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
